// File: rtl/seq_match_controller.sv
// seq_match_controller: arms a serial pattern-match run, counts hits and ends it on target, timeout or abort.
module seq_match_controller #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             timed_out
);
  localparam int FW = $clog2(PAT_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [PAT_W-1:0] pat, pat_n, hist, hist_n, sh;
  logic [CNT_W-1:0] tgt, tgt_n, cnt_n, cnt_inc;
  logic [TO_W-1:0] tmo, tmo_n, timer, timer_n, tick;
  logic [FW-1:0] fill, fill_n, fill_inc;
  logic ovl, ovl_n, hit, pulse_n, done_n, to_n;
  assign sh = {hist[PAT_W-2:0], din};
  assign fill_inc = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
  assign hit = din_valid && fill_inc == FW'(PAT_W) && sh == pat;
  assign cnt_inc = &match_count ? match_count : match_count + 1'b1;
  assign tick = timer + 1'b1;
  always_comb begin
    state_n = state;
    pat_n = pat;
    ovl_n = ovl;
    tgt_n = tgt;
    tmo_n = tmo;
    hist_n = hist;
    fill_n = fill;
    timer_n = timer;
    cnt_n = match_count;
    to_n = timed_out;
    pulse_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        pat_n = cfg_pattern;
        ovl_n = cfg_overlap;
        tgt_n = cfg_target;
        tmo_n = cfg_timeout;
        hist_n = '0;
        fill_n = '0;
        timer_n = '0;
        cnt_n = '0;
        to_n = 1'b0;
      end
      RUN: if (abort) state_n = IDLE;
      else begin
        timer_n = tick;
        if (din_valid) begin
          hist_n = sh;
          fill_n = fill_inc;
        end
        // a hit resets the no-match timer, so it also pre-empts a same-cycle timeout
        if (hit) begin
          pulse_n = 1'b1;
          cnt_n = cnt_inc;
          timer_n = '0;
          if (!ovl) fill_n = '0;
          if (tgt != '0 && cnt_inc == tgt) begin
            state_n = DONE;
            done_n = 1'b1;
          end
        end else if (tmo != '0 && tick == tmo) begin
          state_n = DONE;
          done_n = 1'b1;
          to_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pat <= '0;
      ovl <= 1'b0;
      tgt <= '0;
      tmo <= '0;
      hist <= '0;
      fill <= '0;
      timer <= '0;
      match_count <= '0;
      timed_out <= 1'b0;
      match_pulse <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      pat <= pat_n;
      ovl <= ovl_n;
      tgt <= tgt_n;
      tmo <= tmo_n;
      hist <= hist_n;
      fill <= fill_n;
      timer <= timer_n;
      match_count <= cnt_n;
      timed_out <= to_n;
      match_pulse <= pulse_n;
      done <= done_n;
      busy <= state_n == RUN;
    end
  end
endmodule

// File: tb/tb_seq_match_controller.sv
// tb_seq_match_controller: directed and randomized checks against a queue-based run model.
module tb_seq_match_controller;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic cfg_overlap = 1'b0;
  logic [7:0] cfg_target = '0;
  logic [15:0] cfg_timeout = '0;
  logic start = 1'b0, abort = 1'b0, din = 1'b0, din_valid = 1'b0;
  logic busy, match_pulse, done, timed_out;
  logic [7:0] match_count;
  logic [11:0] dut_vec;
  int n_chk = 0, n_fail = 0;
  // model: phase 0 idle, 1 running, 2 finishing; q holds the unconsumed valid bits
  int phase = 0, since = 0, m_cnt = 0, m_tgt = 0, m_tmo = 0;
  int q[$];
  bit m_pulse = 0, m_done = 0, m_to = 0, m_ovl = 0;
  logic [3:0] m_pat = '0;

  seq_match_controller dut (
    .clk(clk), .reset_n(reset_n), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .cfg_timeout(cfg_timeout), .start(start), .abort(abort),
    .din(din), .din_valid(din_valid), .busy(busy), .match_pulse(match_pulse),
    .match_count(match_count), .done(done), .timed_out(timed_out)
  );

  assign dut_vec = {busy, match_pulse, done, timed_out, match_count};
  always #5 clk = ~clk;

  function automatic logic [11:0] exp_vec();
    logic [7:0] c;
    c = m_cnt[7:0];
    return {phase == 1, m_pulse, m_done, m_to, c};
  endfunction

  task automatic mreset();
    phase = 0; since = 0; m_cnt = 0; m_pulse = 0; m_done = 0; m_to = 0;
    q.delete();
  endtask

  task automatic step(input logic s, input logic a, input logic d, input logic v);
    int val;
    bit h;
    m_pulse = 0;
    m_done = 0;
    if (phase == 0) begin
      if (s) begin
        phase = 1; m_pat = cfg_pattern; m_ovl = cfg_overlap;
        m_tgt = cfg_target; m_tmo = cfg_timeout;
        m_cnt = 0; m_to = 0; since = 0; q.delete();
      end
    end else if (phase == 2 || a) phase = 0;
    else begin
      since++;
      if (v) begin
        q.push_back(int'(d));
        if (q.size() > 4) void'(q.pop_front());
      end
      val = 0;
      foreach (q[i]) val = val * 2 + q[i];
      h = v && q.size() == 4 && val == int'(m_pat);
      if (h) begin
        m_pulse = 1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        since = 0;
        if (!m_ovl) q.delete();
        if (m_tgt != 0 && m_cnt == m_tgt) begin phase = 2; m_done = 1; end
      end else if (m_tmo != 0 && since == m_tmo) begin
        phase = 2; m_done = 1; m_to = 1;
      end
    end
  endtask

  task automatic cyc(input logic s, input logic a, input logic d, input logic v);
    start = s; abort = a; din = d; din_valid = v;
    @(posedge clk);
    step(s, a, d, v);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    mreset();
    n_chk++;
    if (dut_vec !== 12'h000) begin n_fail++; $display("FAIL reset: got %h want 000", dut_vec); end
    #3 reset_n = 1'b1;
    cyc(0, 0, 0, 0);
    n_chk++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_stream(input bit ovl, input logic [7:0] want, input string name);
    logic [6:0] bits = 7'b1101101;
    cfg_pattern = 4'b1101; cfg_overlap = ovl; cfg_target = 0; cfg_timeout = 0;
    cyc(1, 1, 0, 0);
    for (int i = 6; i >= 0; i--) begin
      cyc(0, 0, bits[i], 1);
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL %s bit%0d: got %h want %h", name, 7 - i, dut_vec, exp_vec()); end
    end
    n_chk++;
    if (match_count !== want) begin n_fail++; $display("FAIL %s count: got %0d want %0d", name, match_count, want); end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_target();
    logic [6:0] bits = 7'b1101101;
    cfg_pattern = 4'b1101; cfg_overlap = 1; cfg_target = 2; cfg_timeout = 0;
    cyc(1, 0, 0, 0);
    for (int i = 6; i >= 0; i--) begin
      cyc(0, 0, bits[i], 1);
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL target bit%0d: got %h want %h", 7 - i, dut_vec, exp_vec()); end
    end
    n_chk++;
    if ({done, match_pulse, busy} !== 3'b110) begin n_fail++; $display("FAIL target_end: got %b want 110", {done, match_pulse, busy}); end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1'(i), 1);
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL target_after%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    n_chk++;
    if ({busy, done, match_count} !== {2'b00, 8'd2}) begin n_fail++; $display("FAIL target_idle: got %h want 002", {busy, done, match_count}); end
  endtask

  task automatic test_timeout();
    logic [3:0] bits = 4'b1101;
    cfg_pattern = 4'b1101; cfg_overlap = 1; cfg_target = 0; cfg_timeout = 10;
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0, 0, 1);
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL timeout cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    n_chk++;
    if ({done, timed_out, busy} !== 3'b110) begin n_fail++; $display("FAIL timeout_end: got %b want 110", {done, timed_out, busy}); end
    cyc(0, 0, 0, 0);
    cfg_timeout = 4;
    cyc(1, 0, 0, 0);
    n_chk++;
    if ({timed_out, match_count, busy} !== 10'b0_00000000_1) begin n_fail++; $display("FAIL timeout_clear: got %h want 001", {timed_out, match_count, busy}); end
    for (int i = 3; i >= 0; i--) cyc(0, 0, bits[i], 1);
    n_chk++;
    if ({match_pulse, done, timed_out, busy} !== 4'b1001) begin n_fail++; $display("FAIL match_beats_timeout: got %b want 1001", {match_pulse, done, timed_out, busy}); end
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 0);
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL timeout2 cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_gaps_abort();
    logic [6:0] d = 7'b1100001, v = 7'b1100011;
    cfg_pattern = 4'b1101; cfg_overlap = 1; cfg_target = 0; cfg_timeout = 0;
    cyc(1, 0, 0, 0);
    for (int i = 6; i >= 0; i--) begin
      cyc(0, 0, v[i] ? d[i] : 1'($urandom), v[i]);
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL gaps step%0d: got %h want %h", 7 - i, dut_vec, exp_vec()); end
    end
    n_chk++;
    if (match_count !== 8'd1) begin n_fail++; $display("FAIL gaps_count: got %0d want 1", match_count); end
    cyc(0, 1, 1, 1);
    n_chk++;
    if ({busy, done, match_count} !== {2'b00, 8'd1}) begin n_fail++; $display("FAIL abort: got %h want 001", {busy, done, match_count}); end
    cyc(0, 0, 0, 0);
    n_chk++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL abort_idle: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_reset_midrun();
    logic [9:0] bits = 10'b1101101101;
    cfg_pattern = 4'b1101; cfg_overlap = 1; cfg_target = 0; cfg_timeout = 0;
    cyc(1, 0, 0, 0);
    for (int i = 9; i >= 0; i--) begin
      if (i == 2) cfg_pattern = 4'b0000;
      cyc(i == 2, 0, bits[i], 1);
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL midrun bit%0d: got %h want %h", 10 - i, dut_vec, exp_vec()); end
    end
    n_chk++;
    if ({busy, match_count} !== {1'b1, 8'd3}) begin n_fail++; $display("FAIL midrun_count: got %h want 103", {busy, match_count}); end
    #2 reset_n = 1'b0;
    #1;
    mreset();
    n_chk++;
    if (dut_vec !== 12'h000) begin n_fail++; $display("FAIL async_reset: got %h want 000", dut_vec); end
    #3 reset_n = 1'b1;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    n_chk++;
    if (dut_vec !== exp_vec() || match_pulse !== 1'b1) begin n_fail++; $display("FAIL new_cfg: got %h want %h", dut_vec, exp_vec()); end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_saturate();
    cfg_pattern = 4'b0000; cfg_overlap = 1; cfg_target = 0; cfg_timeout = 0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 270; i++) begin
      cyc(0, 0, 0, 1);
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL saturate cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    n_chk++;
    if (match_count !== 8'hff) begin n_fail++; $display("FAIL saturate_count: got %0d want 255", match_count); end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if (phase == 0 && $urandom_range(3) == 0) begin
        cfg_pattern = 4'($urandom);
        cfg_overlap = 1'($urandom);
        cfg_target = 8'($urandom_range(4));
        cfg_timeout = ($urandom_range(2) == 0) ? 16'd0 : 16'($urandom_range(25, 3));
      end
      cyc($urandom_range(2) == 0, $urandom_range(39) == 0, 1'($urandom), $urandom_range(3) != 0);
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_stream(1, 8'd2, "overlap");
    test_stream(0, 8'd1, "nonoverlap");
    test_target();
    test_timeout();
    test_gaps_abort();
    test_reset_midrun();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
